uart_periph: RTL

- Memory-mapped UART responder on the CPU data bus, at the peripheral window 0x4000_0018..0x4000_0020.
- Serves the firmware's byte I/O:
  - TX data register at +0x00 (0x18).
  - RX data register at +0x04 (0x1C).
  - Control/status register at +0x08 (0x20), which firmware polls for bit 3 (rx_done).
- Contains an 8N1 serializer, an 8N1 deserializer and a shared baud timing scheme. Sits beside data RAM and timer in the bus decode.

---
 rtl/uart_periph_if.sv | 20 ++
 rtl/uart_periph.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph_if.sv
// CPU data-bus view of the UART peripheral: address/strobes/store data in,
// combinational read data and register-select out.
interface uart_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        sel;

    modport master (
        output addr, wdata, MemRead, MemWrite,
        input  rdata, sel
    );

    modport slave (
        input  addr, wdata, MemRead, MemWrite,
        output rdata, sel
    );
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD at BASE, RXD at BASE+4, CON/status at BASE+8.
// Define UART_PERIPH_IRQ_EN to add the irq output and CON[7:6] interrupt masks.
module uart_periph #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic         clk,
    input  logic         reset,
    uart_periph_if.slave bus,
    input  logic         uart_rx,
    output logic         uart_tx
`ifdef UART_PERIPH_IRQ_EN
    ,
    output logic         irq
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

    localparam logic [29:0] TXD_W = BASE_ADDR[31:2];
    localparam logic [29:0] RXD_W = TXD_W + 30'd1;
    localparam logic [29:0] CON_W = TXD_W + 30'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    // register decode
    logic sel_txd, sel_rxd, sel_con;
    logic con_we, txd_we;

    assign sel_txd = (bus.addr[31:2] == TXD_W);
    assign sel_rxd = (bus.addr[31:2] == RXD_W);
    assign sel_con = (bus.addr[31:2] == CON_W);
    assign bus.sel = sel_txd | sel_rxd | sel_con;

    // control / status state
    logic       tx_en, rx_en;
    logic       tx_done, rx_done, overrun;
    logic [7:0] tx_byte;
    logic [7:0] rxd;
    logic       tx_busy;
    logic [1:0] con_hi;

    // transmitter
    uart_state_e tx_state, tx_state_n;
    cnt_t        tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic        tx_end;

    // receiver
    uart_state_e rx_state, rx_state_n;
    cnt_t        rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shreg, rx_shreg_n;
    logic        rx_store;
    logic        rx_s1, rx_s2, rx_prev;

    assign tx_busy = (tx_state != S_IDLE);
    assign con_we  = bus.MemWrite & sel_con;
    assign txd_we  = bus.MemWrite & sel_txd & tx_en & ~tx_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_end     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (txd_we) tx_state_n = S_START;
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + cnt_t'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) tx_state_n = S_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt + cnt_t'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = S_IDLE;
                    tx_end     = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + cnt_t'(1);
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // Line level follows the state register, so an async reset forces idle-high at once.
    always_comb begin
        case (tx_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_byte[tx_bit];
            default: uart_tx = 1'b1;
        endcase
    end

    // 2-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        rx_store   = 1'b0;
        if (!rx_en) begin
            rx_state_n = S_IDLE;
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt_n = '0;
                    if (rx_prev & ~rx_s2) rx_state_n = S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt_n = '0;
                        rx_bit_n = '0;
                        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_n = rx_cnt + cnt_t'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt_n   = '0;
                        rx_shreg_n = {rx_s2, rx_shreg[7:1]};
                        if (rx_bit == 3'd7) rx_state_n = S_STOP;
                        else                rx_bit_n   = rx_bit + 3'd1;
                    end else begin
                        rx_cnt_n = rx_cnt + cnt_t'(1);
                    end
                end
                S_STOP: begin
                    // A low stop bit drops the byte; IDLE needs a fresh 1->0 edge,
                    // so the line must return high before the next frame arms.
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt_n   = '0;
                        rx_state_n = S_IDLE;
                        rx_store   = rx_s2;
                    end else begin
                        rx_cnt_n = rx_cnt + cnt_t'(1);
                    end
                end
                default: rx_state_n = S_IDLE;
            endcase
        end
    end

    // Flag updates: a CON write clears, but a same-cycle set event wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_en   <= 1'b0;
            rx_en   <= 1'b0;
            tx_done <= 1'b0;
            rx_done <= 1'b0;
            overrun <= 1'b0;
            tx_byte <= '0;
            rxd     <= '0;
        end else begin
            if (con_we) begin
                tx_en <= bus.wdata[0];
                rx_en <= bus.wdata[1];
            end
            tx_done <= tx_end | (tx_done & ~con_we);
            rx_done <= rx_store | (rx_done & ~con_we);
            overrun <= (rx_store & rx_done) | (overrun & ~con_we);
            if (txd_we)   tx_byte <= bus.wdata[7:0];
            if (rx_store) rxd     <= rx_shreg;
        end
    end

`ifdef UART_PERIPH_IRQ_EN
    logic rx_ie, tx_ie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (con_we) begin
                rx_ie <= bus.wdata[7];
                tx_ie <= bus.wdata[6];
            end
            irq <= (rx_done & rx_en & rx_ie) | (tx_done & tx_en & tx_ie);
        end
    end

    assign con_hi = {rx_ie, tx_ie};

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};
`else
    assign con_hi = 2'b00;

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.wdata[5:2], bus.addr[1:0]};
`endif

    always_comb begin
        bus.rdata = '0;
        if (bus.MemRead) begin
            if (sel_txd)
                bus.rdata = {24'b0, tx_byte};
            else if (sel_rxd)
                bus.rdata = {24'b0, rxd};
            else if (sel_con)
                bus.rdata = {24'b0, con_hi, overrun, tx_busy, rx_done, tx_done, rx_en, tx_en};
        end
    end

endmodule
